cv32e40n_data_arb: RTL and testbench

CV32E40N_DATA_ARB -- requirements
Module: cv32e40n_data_arb

---
 rtl/cv32e40n_data_arb.sv | 153 +++++++++++++++
 tb/tb_cv32e40n_data_arb.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40n_data_arb.sv
// Round-robin arbiter merging several OBI data masters onto one slave port,
// with an in-order ID FIFO that routes each response back to its requester.
module cv32e40n_data_arb #(
  parameter  int NUM_MASTERS     = 2,
  parameter  int ADDR_WIDTH      = 32,
  parameter  int DATA_WIDTH      = 32,
  parameter  int MAX_OUTSTANDING = 2,
  localparam int BE_W            = DATA_WIDTH / 8,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_MASTERS-1:0]            m_req_i,
  output logic [NUM_MASTERS-1:0]            m_gnt_o,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*BE_W-1:0]       m_be_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
  output logic [NUM_MASTERS-1:0]            m_rvalid_o,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata_o,
  output logic                              s_req_o,
  input  logic                              s_gnt_i,
  input  logic                              s_rvalid_i,
  output logic [ADDR_WIDTH-1:0]             s_addr_o,
  output logic                              s_we_o,
  output logic [BE_W-1:0]                   s_be_o,
  output logic [DATA_WIDTH-1:0]             s_wdata_o,
  input  logic [DATA_WIDTH-1:0]             s_rdata_i,
  output logic [CNT_W-1:0]                  outstanding_o,
  output logic                              rsp_err_o
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);

  logic [IDX_W-1:0] r_rr_ptr;
  logic             r_locked;
  logic [IDX_W-1:0] r_lock_idx;
  logic [IDX_W-1:0] r_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_rsp_err;

  logic [IDX_W-1:0] w_rr_idx;
  logic [IDX_W-1:0] w_sel;
  logic [IDX_W-1:0] w_head;
  logic             w_hs;
  logic             w_pop;

  always_comb begin
    int v_sum;
    logic v_found;
    w_rr_idx = r_rr_ptr;
    v_found  = 1'b0;
    v_sum    = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      v_sum = int'(r_rr_ptr) + i;
      if (v_sum >= NUM_MASTERS) begin
        v_sum = v_sum - NUM_MASTERS;
      end else begin
        v_sum = v_sum;
      end
      if (!v_found && m_req_i[v_sum]) begin
        v_found  = 1'b1;
        w_rr_idx = IDX_W'(v_sum);
      end else begin
        v_found  = v_found;
      end
    end
  end

  // A stalled request keeps its master until the slave grants it.
  assign w_sel   = r_locked ? r_lock_idx : w_rr_idx;
  assign s_req_o = (|m_req_i) && (r_count < MAX_CNT);
  assign w_hs    = s_req_o & s_gnt_i;
  assign w_pop   = s_rvalid_i && (r_count != '0);
  assign w_head  = r_fifo[r_rptr];

  always_comb begin
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    if (s_req_o) begin
      s_addr_o  = m_addr_i[int'(w_sel)*ADDR_WIDTH +: ADDR_WIDTH];
      s_we_o    = m_we_i[w_sel];
      s_be_o    = m_be_i[int'(w_sel)*BE_W +: BE_W];
      s_wdata_o = m_wdata_i[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      s_addr_o  = '0;
      s_we_o    = 1'b0;
      s_be_o    = '0;
      s_wdata_o = '0;
    end
    if (w_hs) begin
      m_gnt_o[w_sel] = 1'b1;
    end else begin
      m_gnt_o = '0;
    end
    if (w_pop) begin
      m_rvalid_o[w_head] = 1'b1;
      m_rdata_o[int'(w_head)*DATA_WIDTH +: DATA_WIDTH] = s_rdata_i;
    end else begin
      m_rvalid_o = '0;
    end
  end

  // A response arriving with nothing outstanding pops nothing and only raises the error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr   <= '0;
      r_locked   <= 1'b0;
      r_lock_idx <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_rsp_err  <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_fifo[i] <= '0;
      end
    end else begin
      if (w_hs) begin
        r_rr_ptr      <= (w_sel == LAST_IDX) ? '0 : w_sel + 1'b1;
        r_locked      <= 1'b0;
        r_fifo[r_wptr] <= w_sel;
        r_wptr        <= (r_wptr == LAST_PTR) ? '0 : r_wptr + 1'b1;
      end else if (s_req_o) begin
        r_locked   <= 1'b1;
        r_lock_idx <= w_sel;
      end else begin
        r_locked   <= r_locked;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + 1'b1;
      end else begin
        r_rptr <= r_rptr;
      end
      if (s_rvalid_i && (r_count == '0)) begin
        r_rsp_err <= 1'b1;
      end else begin
        r_rsp_err <= r_rsp_err;
      end
      r_count <= r_count + CNT_W'(w_hs) - CNT_W'(w_pop);
    end
  end

  assign outstanding_o = r_count;
  assign rsp_err_o     = r_rsp_err;

endmodule

// File: tb/tb_cv32e40n_data_arb.sv
// Bench for cv32e40n_data_arb: directed scenarios plus random traffic, all
// checked against a queue-based model of the arbitration and response rules.
module tb_cv32e40n_data_arb;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MO = 2;
  localparam int CW = $clog2(MO + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_req, m_gnt, m_we, m_rvalid;
  logic [N*AW-1:0] m_addr;
  logic [N*BW-1:0] m_be;
  logic [N*DW-1:0] m_wdata, m_rdata;
  logic            s_req, s_gnt, s_rvalid, s_we, rsp_err;
  logic [AW-1:0]   s_addr;
  logic [BW-1:0]   s_be;
  logic [DW-1:0]   s_wdata, s_rdata;
  logic [CW-1:0]   outstanding;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state
  int mdl_rr = 0;
  bit mdl_locked = 1'b0;
  int mdl_lock_idx = 0;
  int mdl_q[$];
  bit mdl_err = 1'b0;

  cv32e40n_data_arb #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
    .clk_i(clk), .rst_i(rst),
    .m_req_i(m_req), .m_gnt_o(m_gnt), .m_addr_i(m_addr), .m_we_i(m_we),
    .m_be_i(m_be), .m_wdata_i(m_wdata), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata),
    .s_req_o(s_req), .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_addr_o(s_addr),
    .s_we_o(s_we), .s_be_o(s_be), .s_wdata_o(s_wdata), .s_rdata_i(s_rdata),
    .outstanding_o(outstanding), .rsp_err_o(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [N-1:0] req, input logic gnt, input logic rv, input logic [DW-1:0] rd);
    m_req    = req;
    s_gnt    = gnt;
    s_rvalid = rv;
    s_rdata  = rd;
  endtask

  // Check all outputs against the model, then advance one clock and update the model.
  task automatic run_cycle();
    int sel;
    int head;
    bit exp_req, hs, had;
    logic [N-1:0] exp_gnt, exp_rv;
    logic [N*DW-1:0] exp_rd;
    #1;
    sel = -1;
    if (mdl_locked) sel = mdl_lock_idx;
    else begin
      for (int i = 0; i < N; i++) begin
        if (sel < 0 && m_req[(mdl_rr + i) % N]) sel = (mdl_rr + i) % N;
      end
    end
    exp_req = (m_req != '0) && (mdl_q.size() < MO);
    hs      = exp_req && s_gnt;
    exp_gnt = '0;
    if (hs) exp_gnt[sel] = 1'b1;
    had    = (mdl_q.size() > 0);
    exp_rv = '0;
    exp_rd = '0;
    head   = had ? mdl_q[0] : 0;
    if (s_rvalid && had) begin
      exp_rv[head] = 1'b1;
      exp_rd[head*DW +: DW] = s_rdata;
    end
    check_val("s_req", s_req, exp_req);
    check_val("m_gnt", m_gnt, exp_gnt);
    check_val("s_addr", s_addr, exp_req ? m_addr[sel*AW +: AW] : '0);
    check_val("s_we", s_we, exp_req ? m_we[sel] : 1'b0);
    check_val("s_be", s_be, exp_req ? m_be[sel*BW +: BW] : '0);
    check_val("s_wdata", s_wdata, exp_req ? m_wdata[sel*DW +: DW] : '0);
    check_val("m_rvalid", m_rvalid, exp_rv);
    check_val("m_rdata", m_rdata, exp_rd);
    check_val("outstanding", outstanding, mdl_q.size());
    check_val("rsp_err", rsp_err, mdl_err);
    @(posedge clk);
    if (rst) begin
      mdl_rr = 0; mdl_locked = 1'b0; mdl_q.delete(); mdl_err = 1'b0;
    end else begin
      if (s_rvalid && had) void'(mdl_q.pop_front());
      if (s_rvalid && !had) mdl_err = 1'b1;
      if (hs) begin
        mdl_rr = (sel + 1) % N;
        mdl_locked = 1'b0;
        mdl_q.push_back(sel);
      end else if (exp_req) begin
        mdl_locked = 1'b1;
        mdl_lock_idx = sel;
      end
    end
    @(negedge clk);
  endtask

  task automatic reset_cycle();
    rst = 1'b1;
    set_in('0, 1'b0, 1'b0, '0);
    run_cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    m_we = 2'b01; m_be = 8'hF3; m_wdata = 64'h5555_6666_7777_8888;
    m_addr = {32'hB000_0001, 32'hA000_0000};
    set_in('0, 1'b0, 1'b0, '0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("reset_outstanding", outstanding, 0);
    check_val("reset_err", rsp_err, 1'b0);
    run_cycle();

    // Both masters requesting with a continuous grant alternate from m0.
    for (int i = 0; i < 4; i++) begin
      set_in(2'b11, 1'b1, i > 0, 32'h0000_1000 + i);
      #1;
      check_val("rr_alternate", m_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
      run_cycle();
    end
    reset_cycle();

    // m1 stalls while m0 joins; m1 keeps the port until granted.
    for (int c = 0; c < 3; c++) begin
      set_in((c >= 1) ? 2'b11 : 2'b10, 1'b0, 1'b0, '0);
      run_cycle();
    end
    set_in(2'b11, 1'b1, 1'b0, '0);
    #1;
    check_val("lock_addr", s_addr, 32'hB000_0001);
    check_val("lock_gnt", m_gnt, 2'b10);
    run_cycle();
    #1;
    check_val("after_lock_gnt", m_gnt, 2'b01);
    run_cycle();

    // Full: no requests, even while a response pops.
    #1;
    check_val("full_sreq", s_req, 1'b0);
    check_val("full_cnt", outstanding, 2);
    run_cycle();
    set_in(2'b11, 1'b1, 1'b1, 32'hDEAD_BEEF);
    #1;
    check_val("full_rvalid", m_rvalid, 2'b10);
    check_val("full_rdata", m_rdata, 64'hDEAD_BEEF_0000_0000);
    check_val("full_pop_sreq", s_req, 1'b0);
    run_cycle();
    set_in(2'b11, 1'b0, 1'b0, '0);
    #1;
    check_val("resume_sreq", s_req, 1'b1);
    run_cycle();
    reset_cycle();

    // Responses return in grant order.
    set_in(2'b11, 1'b1, 1'b0, '0);
    run_cycle();
    run_cycle();
    set_in(2'b00, 1'b0, 1'b1, 32'h1111_1111);
    #1;
    check_val("order_rv0", m_rvalid, 2'b01);
    check_val("order_rd0", m_rdata, 64'h0000_0000_1111_1111);
    run_cycle();
    set_in(2'b00, 1'b0, 1'b1, 32'h2222_2222);
    #1;
    check_val("order_rv1", m_rvalid, 2'b10);
    check_val("order_rd1", m_rdata, 64'h2222_2222_0000_0000);
    run_cycle();

    // Unsolicited response.
    set_in(2'b00, 1'b0, 1'b1, 32'h3333_3333);
    #1;
    check_val("orphan_rvalid", m_rvalid, 2'b00);
    run_cycle();
    for (int i = 0; i < 3; i++) begin
      set_in(2'b00, 1'b0, 1'b0, '0);
      #1;
      check_val("err_sticky", rsp_err, 1'b1);
      run_cycle();
    end

    // Reset with two outstanding and rr pointer at m1.
    set_in(2'b10, 1'b1, 1'b0, '0);
    run_cycle();
    set_in(2'b01, 1'b1, 1'b0, '0);
    run_cycle();
    #1;
    check_val("prerst_cnt", outstanding, 2);
    reset_cycle();
    set_in(2'b11, 1'b1, 1'b0, '0);
    #1;
    check_val("postrst_cnt", outstanding, 0);
    check_val("postrst_err", rsp_err, 1'b0);
    check_val("postrst_gnt", m_gnt, 2'b01);
    run_cycle();

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      rst      = ($urandom_range(0, 49) == 0);
      m_req    = 2'($urandom_range(0, 3));
      m_addr   = {$urandom, $urandom};
      m_wdata  = {$urandom, $urandom};
      m_be     = 8'($urandom);
      m_we     = 2'($urandom_range(0, 3));
      s_gnt    = ($urandom_range(0, 2) != 0);
      s_rvalid = ($urandom_range(0, 2) == 0);
      s_rdata  = $urandom;
      run_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
